// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bus of the dual-clock FIFO. It carries the two producer
// handshakes, the synchronized read pointer, and the memory write port.
// Optional: FIFO_WR_ALMOST_FULL_EN adds the w_almost_full signal.
interface fifo_wr_arbiter_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned PTR_SIZE   = 4
);
   logic                  req0_valid;
   logic [DATA_WIDTH-1:0] req0_data;
   logic                  req0_last;
   logic                  req0_ready;
   logic                  req1_valid;
   logic [DATA_WIDTH-1:0] req1_data;
   logic                  req1_last;
   logic                  req1_ready;
   logic [PTR_SIZE-1:0]   wq2_rptr;
   logic [DATA_WIDTH-1:0] w_data;
   logic [PTR_SIZE-2:0]   w_addr;
   logic                  w_inc;
   logic                  w_full;
   logic [PTR_SIZE-1:0]   wptr;
`ifdef FIFO_WR_ALMOST_FULL_EN
   logic                  w_almost_full;
`endif

   // Producer / environment side
   modport master (
      output req0_valid, req0_data, req0_last,
      output req1_valid, req1_data, req1_last,
      output wq2_rptr,
      input  req0_ready, req1_ready,
      input  w_data, w_addr, w_inc, w_full, wptr
`ifdef FIFO_WR_ALMOST_FULL_EN
      , input w_almost_full
`endif
   );

   // Arbiter side
   modport slave (
      input  req0_valid, req0_data, req0_last,
      input  req1_valid, req1_data, req1_last,
      input  wq2_rptr,
      output req0_ready, req1_ready,
      output w_data, w_addr, w_inc, w_full, wptr
`ifdef FIFO_WR_ALMOST_FULL_EN
      , output w_almost_full
`endif
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Write-side controller of the dual-clock FIFO. It arbitrates the single
// write port between two framed producers using frame-aware round-robin.
// It also owns the binary/Gray write pointer and the registered full flag.
// Optional: FIFO_WR_ALMOST_FULL_EN adds the registered w_almost_full flag.
module fifo_wr_arbiter #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned PTR_SIZE   = 4
) (
   input logic              wclk,
   input logic              wrst,
   fifo_wr_arbiter_if.slave bus
);

   localparam int unsigned ADDR_W = PTR_SIZE - 1;
   localparam int unsigned DEPTH  = 1 << ADDR_W;

   typedef enum logic [1:0] {ST_IDLE, ST_OWN0, ST_OWN1} state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic                  r_last_grant;
   logic                  w_gnt0;
   logic                  w_gnt1;
   logic                  w_rdy0;
   logic                  w_rdy1;
   logic                  w_inc;
   logic [PTR_SIZE-1:0]   r_wbin;
   logic [PTR_SIZE-1:0]   r_wptr;
   logic [PTR_SIZE-1:0]   w_wbin_next;
   logic [PTR_SIZE-1:0]   w_wgray_next;
   logic [PTR_SIZE-1:0]   w_full_cmp;
   logic                  r_full;
   logic [DATA_WIDTH-1:0] r_wdata_hold;

   // Arbitration state and round-robin history
   always_ff @(posedge wclk) begin
      if (wrst) begin
         r_state      <= ST_IDLE;
         r_last_grant <= 1'b1;
      end else begin
         r_state <= w_state_next;
         if (w_rdy0)      r_last_grant <= 1'b0;
         else if (w_rdy1) r_last_grant <= 1'b1;
      end
   end

   // Next state: an accepted beat opens or closes its frame; otherwise hold
   always_comb begin
      w_state_next = r_state;
      if (w_rdy0)      w_state_next = bus.req0_last ? ST_IDLE : ST_OWN0;
      else if (w_rdy1) w_state_next = bus.req1_last ? ST_IDLE : ST_OWN1;
   end

   // Grants and acceptance; the owner of an open frame keeps the port
   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.req0_valid && (!bus.req1_valid || r_last_grant)) w_gnt0 = 1'b1;
            else if (bus.req1_valid)                                 w_gnt1 = 1'b1;
         end
         ST_OWN0: w_gnt0 = 1'b1;
         ST_OWN1: w_gnt1 = 1'b1;
         default: ;
      endcase
      w_rdy0 = w_gnt0 && bus.req0_valid && !r_full;
      w_rdy1 = w_gnt1 && bus.req1_valid && !r_full;
      w_inc  = w_rdy0 || w_rdy1;
   end

   assign bus.req0_ready = w_rdy0;
   assign bus.req1_ready = w_rdy1;
   assign bus.w_inc      = w_inc;
   assign bus.w_data     = w_rdy1 ? bus.req1_data :
                           (w_rdy0 ? bus.req0_data : r_wdata_hold);
   assign bus.w_addr     = r_wbin[ADDR_W-1:0];
   assign bus.wptr       = r_wptr;
   assign bus.w_full     = r_full;

   // Last written word, presented on w_data while idle
   always_ff @(posedge wclk) begin
      if (wrst)       r_wdata_hold <= '0;
      else if (w_inc) r_wdata_hold <= bus.w_data;
   end

   // Next pointer values and full compare (read pointer with top two bits inverted)
   always_comb begin
      w_wbin_next  = r_wbin + PTR_SIZE'(w_inc);
      w_wgray_next = (w_wbin_next >> 1) ^ w_wbin_next;
      w_full_cmp   = {~bus.wq2_rptr[PTR_SIZE-1:PTR_SIZE-2], bus.wq2_rptr[PTR_SIZE-3:0]};
   end

   // Write pointer and full flag
   always_ff @(posedge wclk) begin
      if (wrst) begin
         r_wbin <= '0;
         r_wptr <= '0;
         r_full <= 1'b0;
      end else begin
         r_wbin <= w_wbin_next;
         r_wptr <= w_wgray_next;
         r_full <= (w_wgray_next == w_full_cmp);
      end
   end

`ifdef FIFO_WR_ALMOST_FULL_EN
   logic [PTR_SIZE-1:0] w_rbin_s;
   logic [PTR_SIZE-1:0] w_fill_next;
   logic                r_almost_full;

   // Gray-to-binary of the synchronized read pointer, and next fill level
   always_comb begin
      w_rbin_s = '0;
      for (int unsigned i = 0; i < PTR_SIZE; i++) begin
         w_rbin_s[i] = ^(bus.wq2_rptr >> i);
      end
      w_fill_next = w_wbin_next - w_rbin_s;
   end

   // Almost full: at most one free slot after this edge
   always_ff @(posedge wclk) begin
      if (wrst) r_almost_full <= 1'b0;
      else      r_almost_full <= (w_fill_next >= PTR_SIZE'(DEPTH - 1));
   end

   assign bus.w_almost_full = r_almost_full;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (DATA_WIDTH=8, PTR_SIZE=4, depth 8).
module tb_fifo_wr_arbiter;

   logic wclk = 1'b0;
   logic wrst;
   int   vectors    = 0;
   int   miscompares = 0;

   fifo_wr_arbiter_if #(.DATA_WIDTH(8), .PTR_SIZE(4)) bus ();

   fifo_wr_arbiter #(.DATA_WIDTH(8), .PTR_SIZE(4)) dut (
      .wclk (wclk),
      .wrst (wrst),
      .bus  (bus.slave)
   );

   always #5 wclk = ~wclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge wclk);
      #1;
   endtask

   task automatic set0(input logic v, input logic [7:0] d, input logic l);
      bus.req0_valid = v;
      bus.req0_data  = d;
      bus.req0_last  = l;
   endtask

   task automatic set1(input logic v, input logic [7:0] d, input logic l);
      bus.req1_valid = v;
      bus.req1_data  = d;
      bus.req1_last  = l;
   endtask

   task automatic do_reset;
      wrst = 1'b1;
      set0(1'b0, 8'h00, 1'b0);
      set1(1'b0, 8'h00, 1'b0);
      bus.wq2_rptr = 4'b0000;
      tick;
      tick;
      wrst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      do_reset;
      chk("rst_wptr", 32'(bus.wptr), 32'h0);
      chk("rst_full", 32'(bus.w_full), 32'h0);
      chk("rst_inc", 32'(bus.w_inc), 32'h0);
      chk("rst_addr", 32'(bus.w_addr), 32'h0);

      // req0 alone: 0x11 then 0x22 (last)
      set0(1'b1, 8'h11, 1'b0); #1;
      chk("t1_rdy0_a", 32'(bus.req0_ready), 32'h1);
      chk("t1_data_a", 32'(bus.w_data), 32'h11);
      chk("t1_addr_a", 32'(bus.w_addr), 32'h0);
      tick;
      chk("t1_wptr_a", 32'(bus.wptr), 32'b0001);
      set0(1'b1, 8'h22, 1'b1); #1;
      chk("t1_rdy0_b", 32'(bus.req0_ready), 32'h1);
      chk("t1_data_b", 32'(bus.w_data), 32'h22);
      chk("t1_addr_b", 32'(bus.w_addr), 32'h1);
      tick;
      chk("t1_wptr_b", 32'(bus.wptr), 32'b0011);
      chk("t1_full", 32'(bus.w_full), 32'h0);
      set0(1'b0, 8'h00, 1'b0); #1;
      chk("t1_idle_inc", 32'(bus.w_inc), 32'h0);
      chk("t1_hold_data", 32'(bus.w_data), 32'h22);

      // Both valid, single-beat frames: A0, B0, A1, B1
      do_reset;
      set0(1'b1, 8'hA0, 1'b1); set1(1'b1, 8'hB0, 1'b1); #1;
      chk("t2_c1_rdy", {30'b0, bus.req1_ready, bus.req0_ready}, 32'b01);
      chk("t2_c1_data", 32'(bus.w_data), 32'hA0);
      tick;
      set0(1'b1, 8'hA1, 1'b1); #1;
      chk("t2_c2_rdy", {30'b0, bus.req1_ready, bus.req0_ready}, 32'b10);
      chk("t2_c2_data", 32'(bus.w_data), 32'hB0);
      tick;
      set1(1'b1, 8'hB1, 1'b1); #1;
      chk("t2_c3_rdy", {30'b0, bus.req1_ready, bus.req0_ready}, 32'b01);
      chk("t2_c3_data", 32'(bus.w_data), 32'hA1);
      tick;
      set0(1'b0, 8'h00, 1'b0); #1;
      chk("t2_c4_rdy", {30'b0, bus.req1_ready, bus.req0_ready}, 32'b10);
      chk("t2_c4_data", 32'(bus.w_data), 32'hB1);
      tick;
      set1(1'b0, 8'h00, 1'b0);
      chk("t2_wptr", 32'(bus.wptr), 32'b0110);

      // req1 two-beat frame (with a stall) while req0 waits
      do_reset;
      set0(1'b1, 8'hD0, 1'b1); #1;
      chk("t3_d0_rdy0", 32'(bus.req0_ready), 32'h1);
      tick;
      set0(1'b1, 8'hD1, 1'b1); set1(1'b1, 8'hC0, 1'b0); #1;
      chk("t3_c0_rdy", {30'b0, bus.req1_ready, bus.req0_ready}, 32'b10);
      chk("t3_c0_data", 32'(bus.w_data), 32'hC0);
      tick;
      set1(1'b0, 8'h00, 1'b0); #1;
      chk("t3_stall_rdy", {30'b0, bus.req1_ready, bus.req0_ready}, 32'b00);
      chk("t3_stall_inc", 32'(bus.w_inc), 32'h0);
      tick;
      set1(1'b1, 8'hC1, 1'b1); #1;
      chk("t3_c1_rdy", {30'b0, bus.req1_ready, bus.req0_ready}, 32'b10);
      chk("t3_c1_data", 32'(bus.w_data), 32'hC1);
      tick;
      set1(1'b0, 8'h00, 1'b0); #1;
      chk("t3_d1_rdy", {30'b0, bus.req1_ready, bus.req0_ready}, 32'b01);
      chk("t3_d1_data", 32'(bus.w_data), 32'hD1);
      tick;
      set0(1'b0, 8'h00, 1'b0);
      chk("t3_wptr", 32'(bus.wptr), 32'b0110);

      // Fill to full with rptr=0, then release one slot
      do_reset;
      for (int i = 0; i < 8; i++) begin
         set0(1'b1, 8'(8'h40 + i), 1'b1); #1;
         chk("t4_rdy0", 32'(bus.req0_ready), 32'h1);
         chk("t4_addr", 32'(bus.w_addr), 32'(i));
         chk("t4_full_pre", 32'(bus.w_full), 32'h0);
         tick;
      end
      chk("t4_full", 32'(bus.w_full), 32'h1);
      chk("t4_wptr_full", 32'(bus.wptr), 32'b1100);
      set0(1'b1, 8'h48, 1'b1); #1;
      chk("t4_blocked_rdy", 32'(bus.req0_ready), 32'h0);
      chk("t4_blocked_inc", 32'(bus.w_inc), 32'h0);
      tick;
      chk("t4_wptr_hold", 32'(bus.wptr), 32'b1100);
      chk("t4_full_hold", 32'(bus.w_full), 32'h1);
      bus.wq2_rptr = 4'b0001;
      tick;
      chk("t4_full_clr", 32'(bus.w_full), 32'h0);
      chk("t4_rdy_after", 32'(bus.req0_ready), 32'h1);
      chk("t4_addr_wrap", 32'(bus.w_addr), 32'h0);
      chk("t4_data_after", 32'(bus.w_data), 32'h48);
      tick;
      set0(1'b0, 8'h00, 1'b0);
      chk("t4_wptr_wrap", 32'(bus.wptr), 32'b1101);

      // Reset in the middle of a req1 frame
      do_reset;
      for (int i = 0; i < 3; i++) begin
         set1(1'b1, 8'(8'hE0 + i), 1'b0); #1;
         chk("t5_rdy1", 32'(bus.req1_ready), 32'h1);
         tick;
      end
      chk("t5_wptr3", 32'(bus.wptr), 32'b0010);
      set0(1'b1, 8'h55, 1'b1); set1(1'b1, 8'hE3, 1'b0); #1;
      chk("t5_own1_rdy", {30'b0, bus.req1_ready, bus.req0_ready}, 32'b10);
      wrst = 1'b1;
      tick;
      wrst = 1'b0;
      chk("t5_wptr_rst", 32'(bus.wptr), 32'h0);
      chk("t5_full_rst", 32'(bus.w_full), 32'h0);
      chk("t5_addr_rst", 32'(bus.w_addr), 32'h0);
      chk("t5_grant0", {30'b0, bus.req1_ready, bus.req0_ready}, 32'b01);
      chk("t5_data0", 32'(bus.w_data), 32'h55);
      tick;
      set0(1'b0, 8'h00, 1'b0); set1(1'b0, 8'h00, 1'b0);
      chk("t5_wptr_after", 32'(bus.wptr), 32'b0001);

`ifdef FIFO_WR_ALMOST_FULL_EN
      // Almost-full rises on the 7th write and clears after two reads
      do_reset;
      for (int i = 0; i < 7; i++) begin
         set0(1'b1, 8'(8'h70 + i), 1'b1); #1;
         chk("t6_af_pre", 32'(bus.w_almost_full), 32'h0);
         tick;
      end
      set0(1'b0, 8'h00, 1'b0);
      chk("t6_af_set", 32'(bus.w_almost_full), 32'h1);
      chk("t6_full", 32'(bus.w_full), 32'h0);
      bus.wq2_rptr = 4'b0011;
      tick;
      chk("t6_af_clr", 32'(bus.w_almost_full), 32'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
